// File: rtl/bm_dag3_rr_sched.sv
// bm_dag3_rr_sched: round-robin scheduler sharing one bm_dag3-class datapath among NREQ
// requesters, with a tag pipeline returning id-tagged responses and a hold/drain FSM.
// Optional feature: define BM_DAG3_SCHED_CNT_EN to build the saturating issue counter.
module bm_dag3_rr_sched #(
    parameter int unsigned BITS = 2,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned LAT  = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BITS-1:0] a_bus,
    input  logic [NREQ*BITS-1:0] b_bus,
    input  logic [NREQ-1:0]      c_bus,
    input  logic [NREQ-1:0]      d_bus,
    input  logic                 hold,
    output logic [NREQ-1:0]      grant,
    output logic                 dp_vld,
    output logic [BITS-1:0]      dp_a,
    output logic [BITS-1:0]      dp_b,
    output logic                 dp_c,
    output logic                 dp_d,
    input  logic [BITS-1:0]      dp_out0,
    input  logic                 dp_out1,
    output logic                 rsp_vld,
    output logic [IDW-1:0]       rsp_id,
    output logic [BITS-1:0]      rsp_out0,
    output logic                 rsp_out1,
    output logic                 idle,
    output logic [7:0]           issue_cnt
);

    typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  winner;
    logic            found;
    logic            issue;
    logic [NREQ-1:0] grant_q;
    logic            dp_vld_q;
    logic [BITS-1:0] dp_a_q, dp_b_q;
    logic            dp_c_q, dp_d_q;
    logic [LAT:0]    tag_vld_q;
    logic [IDW-1:0]  tag_id_q [LAT+1];
    logic            tag_any;
    logic            rsp_vld_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [BITS-1:0] rsp_out0_q;
    logic            rsp_out1_q;

    // Round-robin search upward from ptr; NREQ == 2**IDW so the index wraps naturally.
    always_comb begin
        logic [IDW-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr_q + k[IDW-1:0];
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Only RUN issues; hold takes precedence over any pending request.
    assign issue   = (state_q == StRun) && !hold && found;
    assign tag_any = |tag_vld_q;

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: DRAIN waits for the tag pipeline to empty before halting.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (hold) state_d = StDrain;
            StDrain: begin
                if (!hold) begin
                    state_d = StRun;
                end else if (!tag_any) begin
                    state_d = StHalt;
                end
            end
            StHalt:  if (!hold) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // Grant, pointer and operand capture; operands hold their last values when idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_q  <= '0;
            dp_vld_q <= 1'b0;
            dp_a_q   <= '0;
            dp_b_q   <= '0;
            dp_c_q   <= 1'b0;
            dp_d_q   <= 1'b0;
            ptr_q    <= '0;
        end else begin
            grant_q  <= issue ? (NREQ'(1) << winner) : '0;
            dp_vld_q <= issue;
            if (issue) begin
                dp_a_q <= a_bus[int'(winner)*BITS +: BITS];
                dp_b_q <= b_bus[int'(winner)*BITS +: BITS];
                dp_c_q <= c_bus[winner];
                dp_d_q <= d_bus[winner];
                ptr_q  <= winner + IDW'(1);
            end
        end
    end

    // Tag pipeline: LAT+1 stages of {valid, id}, aligned so the last stage meets dp_out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_vld_q <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            tag_vld_q   <= {tag_vld_q[LAT-1:0], issue};
            tag_id_q[0] <= winner;
            for (int k = 1; k <= LAT; k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end
        end
    end

    // Response register: capture the datapath result when the final tag stage is valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_out0_q <= '0;
            rsp_out1_q <= 1'b0;
        end else begin
            rsp_vld_q <= tag_vld_q[LAT];
            if (tag_vld_q[LAT]) begin
                rsp_id_q   <= tag_id_q[LAT];
                rsp_out0_q <= dp_out0;
                rsp_out1_q <= dp_out1;
            end
        end
    end

`ifdef BM_DAG3_SCHED_CNT_EN
    logic [7:0] cnt_q;

    // Saturating count of grant edges, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (issue && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign issue_cnt = cnt_q;
`else
    assign issue_cnt = '0;
`endif

    assign grant    = grant_q;
    assign dp_vld   = dp_vld_q;
    assign dp_a     = dp_a_q;
    assign dp_b     = dp_b_q;
    assign dp_c     = dp_c_q;
    assign dp_d     = dp_d_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_out0 = rsp_out0_q;
    assign rsp_out1 = rsp_out1_q;
    assign idle     = (state_q == StHalt);

endmodule

// File: tb/tb_bm_dag3_rr_sched.sv
// Bench for bm_dag3_rr_sched: directed phases plus randomized traffic, checked against a
// cycle-level reference model of the scheduling rules and a stub datapath.
module tb_bm_dag3_rr_sched;

    localparam int unsigned BITS = 2;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned LAT  = 3;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b1;
    logic [NREQ-1:0]      req;
    logic [NREQ*BITS-1:0] a_bus, b_bus;
    logic [NREQ-1:0]      c_bus, d_bus;
    logic                 hold;
    logic [NREQ-1:0]      grant;
    logic                 dp_vld;
    logic [BITS-1:0]      dp_a, dp_b;
    logic                 dp_c, dp_d;
    logic [BITS-1:0]      dp_out0;
    logic                 dp_out1;
    logic                 rsp_vld;
    logic [IDW-1:0]       rsp_id;
    logic [BITS-1:0]      rsp_out0;
    logic                 rsp_out1;
    logic                 idle;
    logic [7:0]           issue_cnt;

    bm_dag3_rr_sched #(.BITS(BITS), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .c_bus(c_bus), .d_bus(d_bus), .hold(hold), .grant(grant), .dp_vld(dp_vld),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d), .dp_out0(dp_out0),
        .dp_out1(dp_out1), .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_out0(rsp_out0),
        .rsp_out1(rsp_out1), .idle(idle), .issue_cnt(issue_cnt)
    );

    always #5 clock = ~clock;

    // Stub datapath function: {out1, out0}.
    function automatic logic [BITS:0] stub_f(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                             input logic c, input logic d);
        logic [BITS-1:0] o0;
        logic            o1;
        o0 = (a + b) ^ {BITS{c}};
        o1 = c ^ d ^ a[0];
        return {o1, o0};
    endfunction

    // Stub datapath: samples dp_* every edge, result valid LAT edges later.
    logic [BITS:0] stub_q [LAT];
    always_ff @(posedge clock) begin
        stub_q[0] <= stub_f(dp_a, dp_b, dp_c, dp_d);
        for (int i = 1; i < LAT; i++) stub_q[i] <= stub_q[i-1];
    end
    assign dp_out0 = stub_q[LAT-1][BITS-1:0];
    assign dp_out1 = stub_q[LAT-1][BITS];

    // Requester operand storage.
    logic [BITS-1:0] ra [NREQ];
    logic [BITS-1:0] rb [NREQ];
    logic            rc [NREQ];
    logic            rd [NREQ];

    always_comb begin
        a_bus = '0;
        b_bus = '0;
        c_bus = '0;
        d_bus = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_bus[i*BITS +: BITS] = ra[i];
            b_bus[i*BITS +: BITS] = rb[i];
            c_bus[i] = rc[i];
            d_bus[i] = rd[i];
        end
    end

    // Reference model state.
    typedef struct {
        int            due;
        int            id;
        logic [BITS:0] res;
    } rsp_t;

    rsp_t            exp_q [$];
    int              m_ptr;
    int              m_mode;  // 0 run, 1 drain, 2 halt
    int              m_cnt;
    int              edge_n;
    logic [BITS-1:0] m_a, m_b;
    logic            m_c, m_d;
    int              total = 0;
    int              bad = 0;
    int              last_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_ptr  = 0;
        m_mode = 0;
        m_cnt  = 0;
        m_a    = '0;
        m_b    = '0;
        m_c    = 1'b0;
        m_d    = 1'b0;
    endtask

    task automatic new_ops(input int i);
        ra[i] = BITS'($urandom);
        rb[i] = BITS'($urandom);
        rc[i] = 1'($urandom);
        rd[i] = 1'($urandom);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_dp_vld", 32'(dp_vld), 32'd0);
        chk("rst_dp_ab", 32'({dp_a, dp_b, dp_c, dp_d}), 32'd0);
        chk("rst_rsp", 32'({rsp_vld, rsp_id, rsp_out0, rsp_out1}), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);
        chk("rst_cnt", 32'(issue_cnt), 32'd0);
        model_clear();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // One clock edge: predict from current inputs, advance, then compare.
    task automatic step(output int g);
        int  nm;
        int  win;
        bit  go;
        go  = 1'b0;
        win = 0;
        if (m_mode == 0 && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (!go && req[i]) begin
                    go  = 1'b1;
                    win = i;
                end
            end
        end
        nm = m_mode;
        case (m_mode)
            0: if (hold) nm = 1;
            1: if (!hold) nm = 0; else if (exp_q.size() == 0) nm = 2;
            default: if (!hold) nm = 0;
        endcase

        @(posedge clock);
        edge_n++;
        #1;

        m_mode = nm;
        if (go) begin
            rsp_t r;
            m_a   = ra[win];
            m_b   = rb[win];
            m_c   = rc[win];
            m_d   = rd[win];
            m_ptr = (win + 1) % NREQ;
`ifdef BM_DAG3_SCHED_CNT_EN
            if (m_cnt < 255) m_cnt++;
`endif
            r.due = edge_n + LAT + 1;
            r.id  = win;
            r.res = stub_f(ra[win], rb[win], rc[win], rd[win]);
            exp_q.push_back(r);
        end
        g = go ? win : -1;

        chk("grant", 32'(grant), go ? (32'd1 << win) : 32'd0);
        chk("dp_vld", 32'(dp_vld), 32'(go));
        chk("dp_ops", 32'({dp_a, dp_b, dp_c, dp_d}), 32'({m_a, m_b, m_c, m_d}));
        chk("idle", 32'(idle), 32'(m_mode == 2));
        chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
        if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
            chk("rsp_vld", 32'(rsp_vld), 32'd1);
            chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
            chk("rsp_out", 32'({rsp_out1, rsp_out0}), 32'(exp_q[0].res));
            void'(exp_q.pop_front());
        end else begin
            chk("rsp_vld", 32'(rsp_vld), 32'd0);
        end
    endtask

    // Requester behaviour after an edge: granted one drops or presents new operands.
    task automatic upd_reqs(input int g, input int p_raise, input int p_drop);
        for (int i = 0; i < NREQ; i++) begin
            if (i == g) begin
                if (int'($urandom_range(99)) < p_drop) req[i] = 1'b0;
                else new_ops(i);
            end else if (!req[i] && int'($urandom_range(99)) < p_raise) begin
                req[i] = 1'b1;
                new_ops(i);
            end
        end
    endtask

    initial begin
        req  = '0;
        hold = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rb[i] = '0;
            rc[i] = 1'b0;
            rd[i] = 1'b0;
        end
        edge_n = 0;
        model_clear();
        #2;
        do_reset();

        // Single request from requester 0.
        ra[0] = 2'b11; rb[0] = 2'b01; rc[0] = 1'b1; rd[0] = 1'b0;
        req = 4'b0001;
        step(last_g);
        req = 4'b0000;
        for (int n = 0; n < 6; n++) step(last_g);

        // Full contention: everyone keeps requesting with fresh operands.
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        for (int n = 0; n < 10; n++) begin
            step(last_g);
            upd_reqs(last_g, 0, 0);
        end
        req = '0;
        for (int n = 0; n < 6; n++) step(last_g);

        // Pointer skip: 0101, then requester 3 joins after the first grant.
        req = 4'b0101;
        new_ops(0);
        new_ops(2);
        step(last_g);
        upd_reqs(last_g, 0, 100);
        req[3] = 1'b1;
        new_ops(3);
        for (int n = 0; n < 4; n++) begin
            step(last_g);
            upd_reqs(last_g, 0, 100);
        end
        for (int n = 0; n < 5; n++) step(last_g);

        // Drain and resume with all requesters pending.
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        for (int n = 0; n < 3; n++) begin
            step(last_g);
            upd_reqs(last_g, 0, 0);
        end
        hold = 1'b1;
        for (int n = 0; n < LAT + 5; n++) step(last_g);
        hold = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step(last_g);
            upd_reqs(last_g, 0, 0);
        end

        // Reset with operations in flight; those must never respond.
        do_reset();
        req = 4'b1011;
        for (int n = 0; n < 8; n++) begin
            step(last_g);
            upd_reqs(last_g, 30, 40);
        end

        // Randomized traffic with occasional hold toggling.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) < 6) hold = ~hold;
            step(last_g);
            upd_reqs(last_g, 40, 50);
        end
        hold = 1'b0;
        req  = '0;
        for (int n = 0; n < 6; n++) step(last_g);

        // Counter saturation: 300 back-to-back grants to a lone requester.
        req = 4'b0001;
        new_ops(0);
        for (int n = 0; n < 300; n++) begin
            step(last_g);
            upd_reqs(last_g, 0, 0);
        end
        req = '0;
        for (int n = 0; n < 6; n++) step(last_g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bm_dag3_rr_sched.md
# bm_dag3_rr_sched

Round-robin scheduler that shares one bm_dag3-class datapath (two BITS-wide operands a/b and two 1-bit operands c/d in; out0/out1 back) among NREQ requesters. It captures one requester's operands per cycle and drives them to the datapath. A LAT-deep tag pipeline returns each result tagged with its requester id. A hold/drain state machine lets system control quiesce the shared datapath.

## Interface
Parameters:
- BITS, 2, operand width of a/b and of out0.
- NREQ, 4, number of requesters; legal values are 2 and 4.
- IDW, 2, id width, ceil(log2(NREQ)).
- LAT, 3, datapath latency in clock edges from dp_vld sampled to matching dp_out0/dp_out1 valid; legal range 1..8.

Ports:
- clock  in  1  rising-edge clock, the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request; held with operands until granted.
- a_bus  in  NREQ*BITS  requester i operand a at [i*BITS +: BITS].
- b_bus  in  NREQ*BITS  requester i operand b, same packing.
- c_bus  in  NREQ  requester i operand c at bit i.
- d_bus  in  NREQ  requester i operand d at bit i.
- hold  in  1  stop issuing and drain the datapath.
- grant  out  NREQ  one-hot registered acknowledge: operands captured at the preceding edge.
- dp_vld  out  1  operands on dp_* are valid this cycle.
- dp_a  out  BITS  datapath operand a.
- dp_b  out  BITS  datapath operand b.
- dp_c  out  1  datapath operand c.
- dp_d  out  1  datapath operand d.
- dp_out0  in  BITS  datapath result out0.
- dp_out1  in  1  datapath result out1.
- rsp_vld  out  1  response valid, one-cycle pulse per issued operation.
- rsp_id  out  IDW  requester index for the response.
- rsp_out0  out  BITS  captured out0.
- rsp_out1  out  1  captured out1.
- idle  out  1  high in HALT: no issue possible, pipeline empty.
- issue_cnt  out  8  issued-operation counter; see Configuration.

## Operation
- **FSM states:** RUN, DRAIN, HALT. Reset state is RUN.
- **RUN:**
  - At each edge with hold=0 and any req bit set, select the first set req bit starting at ptr and searching upward modulo NREQ.
  - Register grant one-hot for the winner, dp_vld=1, and dp_a/b/c/d from the winner's bus slices.
  - Set ptr to winner+1 modulo NREQ.
  - If no req bit is set, grant=0 and dp_vld=0; dp_a/b/c/d hold their last values; ptr is unchanged.
- **Requester rule:** a requester seeing its grant high must, within that cycle, either drop req or present its next operands. A requester that keeps req high with new operands is re-eligible at the next edge under round-robin order. req must not be withdrawn before grant; if it is, nothing is captured for that requester.
- **Tag pipeline:** LAT+1 stages of {valid, id}. Stage 0 loads {dp_vld_next, winner}. At the final stage, rsp_vld is registered together with rsp_id, and rsp_out0/rsp_out1 are registered from dp_out0/dp_out1.
- **Ordering:** responses leave in issue order, at most one per cycle. There is no backpressure; consumers must accept every rsp_vld.
- **RUN→DRAIN:** at an edge with hold=1. No grant at that edge.
- **DRAIN:**
  - No grants.
  - Go to RUN at an edge with hold=0.
  - Otherwise go to HALT at the first edge where all tag stages are invalid.
- **HALT:** idle=1. Go to RUN at an edge with hold=0.
- **hold precedence:** hold=1 with req pending at the same edge means hold wins and nothing is granted.
- **Reset (asynchronous, any time, including mid-drain):**
  - grant, dp_vld, dp_a, dp_b, dp_c, dp_d, rsp_vld, rsp_id, rsp_out0, rsp_out1, idle, issue_cnt and ptr all become 0.
  - All tag stages become invalid; state becomes RUN.
  - In-flight operations are discarded with no response.

## Timing
- Operands sampled at edge E0 → grant and dp_vld high in cycle E0..E0+1.
- The datapath consumes the operands at edge E0+1.
- dp_out is sampled at edge E0+LAT+1 → rsp_vld high in cycle E0+LAT+1..E0+LAT+2.
- Issue throughput is 1 per cycle.
- A requester that is pending alone, with req held and no hold, is granted every cycle.
- With all NREQ requesters pending, each is granted exactly once per NREQ cycles.
- DRAIN→HALT takes at most LAT+2 edges after hold is sampled.

## Configuration
- **BM_DAG3_SCHED_CNT_EN defined:** issue_cnt increments by 1 at every grant edge, saturates at 255, and is cleared only by reset.
- **Macro undefined:** issue_cnt is tied to 0 and no counter logic is built.

## Test plan
- **Reset check:** assert reset_n=0 mid-stream with 3 operations in flight → all outputs 0 asynchronously. After release, no rsp_vld until new issues; the first grant goes to requester 0 if pending.
- **Single request, LAT=3:** req=0001, a=2'b11, b=2'b01, c=1, d=0 sampled at E0 → grant=0001 and dp_vld in cycle E0+1. With a stub datapath, rsp_vld=1, rsp_id=0 and rsp_out0 = the stub result in cycle E0+4.
- **Full contention:** req=1111 held → grant sequence 0001, 0010, 0100, 1000, 0001; rsp_id sequence 0, 1, 2, 3, 0, with each response LAT+1 cycles after its grant.
- **Pointer skip:** req=0101, then 1000 raised after the first grant → grants 0001, 0100, 1000, 0001, with no idle grant cycles.
- **Drain and resume:** hold=1 with 3 operations in flight and req=1111 → no grants; exactly 3 rsp_vld pulses, then idle=1. hold=0 → idle=0 and the next grant resumes at ptr.
- **Counter:** with BM_DAG3_SCHED_CNT_EN, 300 back-to-back grants → issue_cnt=255. Without the macro → issue_cnt=0 throughout.
